// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential step, stall hold and branch redirect.
// Optional redirect-target alignment check is enabled by defining PC_GEN_ALIGN_CHECK_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pc_gen #(
    parameter logic [`PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned          PC_STEP      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [`PC_WIDTH-1:0] redirect_pc_i,
    output logic [`PC_WIDTH-1:0] pc_o,
    output logic                 fetch_en_o,
    output logic                 inst_valid_o,
    output logic [1:0]           state_o,
    output logic                 misalign_o
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [`PC_WIDTH-1:0] STEP_INC   = `PC_WIDTH'(PC_STEP);
    localparam logic [`PC_WIDTH-1:0] ALIGN_MASK = `PC_WIDTH'(PC_STEP - 1);

    state_t               r_state;
    logic [`PC_WIDTH-1:0] r_pc;
    logic                 r_inst_valid;
    logic                 r_misalign;
    logic [`PC_WIDTH-1:0] w_target;
    logic                 w_target_misaligned;

`ifdef PC_GEN_ALIGN_CHECK_EN
    // Low bits below the step granularity are dropped and reported.
    assign w_target            = redirect_pc_i & ~ALIGN_MASK;
    assign w_target_misaligned = |(redirect_pc_i & ALIGN_MASK);
`else
    assign w_target            = redirect_pc_i;
    assign w_target_misaligned = 1'b0;
`endif

    // A redirect fetches even under back-pressure; a plain stall freezes the BRAM.
    assign fetch_en_o = ~rst & (redirect_i | ~stall_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_state      <= S_RST;
        end else if (redirect_i) begin
            r_pc         <= w_target;
            r_inst_valid <= 1'b0;
            r_misalign   <= w_target_misaligned;
            r_state      <= S_FLUSH;
        end else if (stall_i) begin
            r_misalign   <= 1'b0;
            r_state      <= S_STALL;
        end else begin
            r_pc         <= r_pc + STEP_INC;
            r_inst_valid <= 1'b1;
            r_misalign   <= 1'b0;
            r_state      <= S_RUN;
        end
    end

    assign pc_o         = r_pc;
    assign inst_valid_o = r_inst_valid;
    assign misalign_o   = r_misalign;
    assign state_o      = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen: each vector's expected outputs are queued at drive time
// and popped/compared one cycle later after the clock edge.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_pc_gen;

    localparam logic [`PC_WIDTH-1:0] RV = `PC_WIDTH'h100;

`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam logic [`PC_WIDTH-1:0] MIS_PC   = `PC_WIDTH'h200;
    localparam logic [`PC_WIDTH-1:0] MIS_NEXT = `PC_WIDTH'h204;
    localparam logic                 MIS_FLAG = 1'b1;
`else
    localparam logic [`PC_WIDTH-1:0] MIS_PC   = `PC_WIDTH'h203;
    localparam logic [`PC_WIDTH-1:0] MIS_NEXT = `PC_WIDTH'h207;
    localparam logic                 MIS_FLAG = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stall_i;
    logic                 redirect_i;
    logic [`PC_WIDTH-1:0] redirect_pc_i;
    logic [`PC_WIDTH-1:0] pc_o;
    logic                 fetch_en_o;
    logic                 inst_valid_o;
    logic [1:0]           state_o;
    logic                 misalign_o;

    always #5 clk = ~clk;

    pc_gen #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (pc_o),
        .fetch_en_o   (fetch_en_o),
        .inst_valid_o (inst_valid_o),
        .state_o      (state_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic                 rst;
        logic                 stall;
        logic                 redir;
        logic [`PC_WIDTH-1:0] tgt;
        logic                 exp_fen;
        logic [`PC_WIDTH-1:0] exp_pc;
        logic                 exp_valid;
        logic [1:0]           exp_state;
        logic                 exp_mis;
    } vec_t;

    typedef struct {
        string                name;
        logic [`PC_WIDTH-1:0] pc;
        logic                 valid;
        logic [1:0]           state;
        logic                 mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string kind, input logic [`PC_WIDTH-1:0] tgt,
                                input logic fen, input logic [`PC_WIDTH-1:0] pc,
                                input logic v, input logic [1:0] st, input logic mis);
        vec_t r;
        r.rst   = (kind == "rst") || (kind == "rstredir");
        r.stall = (kind == "stall") || (kind == "stallredir");
        r.redir = (kind == "redir") || (kind == "stallredir") || (kind == "rstredir");
        r.tgt   = tgt;
        r.exp_fen = fen; r.exp_pc = pc; r.exp_valid = v; r.exp_state = st; r.exp_mis = mis;
        return r;
    endfunction

    task automatic check(input string name, input logic [`PC_WIDTH-1:0] act,
                         input logic [`PC_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; stall_i = v.stall; redirect_i = v.redir; redirect_pc_i = v.tgt;
        #1;
        check({tag, ".fetch_en"}, `PC_WIDTH'(fetch_en_o), `PC_WIDTH'(v.exp_fen));
        e.name = tag; e.pc = v.exp_pc; e.valid = v.exp_valid; e.state = v.exp_state;
        e.mis = v.exp_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".pc"},       pc_o,                      e.pc);
        check({e.name, ".valid"},    `PC_WIDTH'(inst_valid_o),  `PC_WIDTH'(e.valid));
        check({e.name, ".state"},    `PC_WIDTH'(state_o),       `PC_WIDTH'(e.state));
        check({e.name, ".misalign"}, `PC_WIDTH'(misalign_o),    `PC_WIDTH'(e.mis));
        $display("txn %s pc=0x%0h valid=%0b state=%0d fen=%0b mis=%0b",
                 tag, pc_o, inst_valid_o, state_o, fetch_en_o, misalign_o);
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        vecs.push_back(mk("rst",        '0,                0, RV,                 0, 2'd0, 0));
        vecs.push_back(mk("rst",        '0,                0, RV,                 0, 2'd0, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h104,     1, 2'd1, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h108,     1, 2'd1, 0));
        vecs.push_back(mk("stall",      '0,                0, `PC_WIDTH'h108,     1, 2'd2, 0));
        vecs.push_back(mk("stall",      '0,                0, `PC_WIDTH'h108,     1, 2'd2, 0));
        vecs.push_back(mk("stall",      '0,                0, `PC_WIDTH'h108,     1, 2'd2, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h10C,     1, 2'd1, 0));
        vecs.push_back(mk("stallredir", `PC_WIDTH'h200,    1, `PC_WIDTH'h200,     0, 2'd3, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h204,     1, 2'd1, 0));
        vecs.push_back(mk("redir",      `PC_WIDTH'h300,    1, `PC_WIDTH'h300,     0, 2'd3, 0));
        vecs.push_back(mk("redir",      `PC_WIDTH'h400,    1, `PC_WIDTH'h400,     0, 2'd3, 0));
        vecs.push_back(mk("stall",      '0,                0, `PC_WIDTH'h400,     0, 2'd2, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h404,     1, 2'd1, 0));
        vecs.push_back(mk("redir",      {`PC_WIDTH{1'b1}} - `PC_WIDTH'd3,
                                                           1, {`PC_WIDTH{1'b1}} - `PC_WIDTH'd3,
                                                                                  0, 2'd3, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h0,       1, 2'd1, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h4,       1, 2'd1, 0));
        vecs.push_back(mk("rstredir",   `PC_WIDTH'h500,    0, RV,                 0, 2'd0, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h104,     1, 2'd1, 0));
        vecs.push_back(mk("redir",      `PC_WIDTH'h203,    1, MIS_PC,             0, 2'd3, MIS_FLAG));
        vecs.push_back(mk("run",        '0,                1, MIS_NEXT,           1, 2'd1, 0));
        vecs.push_back(mk("redir",      `PC_WIDTH'h208,    1, `PC_WIDTH'h208,     0, 2'd3, 0));
        vecs.push_back(mk("run",        '0,                1, `PC_WIDTH'h20C,     1, 2'd1, 0));

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Redirect on the first cycle after reset release, then a misaligned redirect
        // directly followed by a stall: the flag must drop while the stall holds pc.
        apply("h_rst",    mk("rst",   '0,             0, RV,             0, 2'd0, 0));
        apply("h_redir",  mk("redir", `PC_WIDTH'h600, 1, `PC_WIDTH'h600, 0, 2'd3, 0));
        apply("h_misred", mk("redir", `PC_WIDTH'h702, 1, MIS_FLAG ? `PC_WIDTH'h700 : `PC_WIDTH'h702,
                             0, 2'd3, MIS_FLAG));
        apply("h_stall",  mk("stall", '0,             0, MIS_FLAG ? `PC_WIDTH'h700 : `PC_WIDTH'h702,
                             0, 2'd2, 0));
        apply("h_run",    mk("run",   '0,             1, MIS_FLAG ? `PC_WIDTH'h704 : `PC_WIDTH'h706,
                             1, 2'd1, 0));

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator for the fetch stage: issues the instruction-memory address each cycle, steps it sequentially, and applies stall and branch/jump redirect. It drives the BRAM address register (MAR) and enable, and produces an instruction-valid flag. That flag is aligned with the BRAM data output and with the one-cycle-delayed PC, so decode can discard bubbles and wrong-path slots.

## Interface
Parameters:
- RESET_VECTOR, default 0: fetch address after reset, `PC_WIDTH bits.
- PC_STEP, default 4: sequential increment in bytes.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold current fetch address (downstream back-pressure).
- redirect_i  in  1  taken branch/jump this cycle; has priority over stall_i.
- redirect_pc_i  in  `PC_WIDTH  redirect target; sampled only when redirect_i=1.
- pc_o  out  `PC_WIDTH  registered fetch address to BRAM addr/MAR.
- fetch_en_o  out  1  BRAM/MAR enable; combinational.
- inst_valid_o  out  1  registered; BRAM dout this cycle is a valid in-path instruction.
- state_o  out  2  current FSM state (debug/verification).
- misalign_o  out  1  registered one-cycle pulse on misaligned redirect target (see Configuration).

## Operation
- FSM states: S_RST=0, S_RUN=1, S_STALL=2, S_FLUSH=3.
- fetch_en_o = ~rst & (redirect_i | ~stall_i).
- Each posedge with rst=0 applies the first matching rule, in priority order:
  - redirect_i=1: pc_o<=redirect_pc_i; inst_valid_o<=0; state<=S_FLUSH. Any stall_i is ignored.
  - stall_i=1: pc_o and inst_valid_o hold; state<=S_STALL.
  - otherwise: pc_o<=pc_o+PC_STEP; inst_valid_o<=1; state<=S_RUN.
- The address in pc_o is fetched in the cycle it is presented. The first post-reset fetch is RESET_VECTOR, so pc_o steps to RESET_VECTOR+PC_STEP.
- S_FLUSH lasts exactly one cycle unless a further redirect or stall occurs. The dout in that cycle belongs to the old path and is marked invalid.
- Arithmetic: pc_o+PC_STEP truncated to `PC_WIDTH and wraps modulo 2^`PC_WIDTH. No carry or overflow flag.
- Back-to-back redirects: each one takes effect. inst_valid_o stays 0 until the first non-redirect, non-stall cycle.
- Redirect during stall: accepted immediately; the stall is dropped for that cycle.

## Timing
- Reset values (posedge with rst=1): pc_o=RESET_VECTOR, inst_valid_o=0, misalign_o=0, state_o=S_RST. fetch_en_o=0 while rst=1.
- Reset mid-operation overrides all inputs: a pending redirect is discarded, and the next fetch is RESET_VECTOR.
- Latency: an address in pc_o at cycle n yields BRAM dout and the delayed PC at cycle n+1. inst_valid_o at n+1 qualifies that slot.
- Redirect latency: redirect_i at cycle n puts the target on pc_o at n+1. The target instruction appears at n+2 with inst_valid_o=1.
- Stall: fetch_en_o=0 in the same cycle, so the BRAM output register holds. inst_valid_o is unchanged.

## Configuration
- PC_GEN_ALIGN_CHECK_EN defined:
  - A redirect with non-zero low log2(PC_STEP) target bits loads pc_o with those bits forced to 0.
  - misalign_o=1 for exactly the following cycle.
- Undefined: the target is loaded unmodified, and misalign_o is tied to 0.

## Test plan
- Reset release, RESET_VECTOR=0x100, no stall: pc_o=0x100,0x104,0x108; inst_valid_o=0,1,1; state_o=0,1,1.
- Stall for 3 cycles at pc_o=0x108: fetch_en_o=0 and pc_o=0x108 throughout, inst_valid_o held at 1, state_o=2. After release, pc_o=0x10C next cycle.
- Redirect to 0x200 while stall_i=1 at pc_o=0x10C: next cycle pc_o=0x200, inst_valid_o=0, state_o=3. The following cycle pc_o=0x204, inst_valid_o=1.
- Wrap: pc_o=2^`PC_WIDTH-4 with no stall gives next pc_o=0.
- rst asserted during a redirect cycle: next pc_o=RESET_VECTOR, inst_valid_o=0, state_o=0.
- With PC_GEN_ALIGN_CHECK_EN, redirect to 0x203: pc_o=0x200 and misalign_o=1 for one cycle only. Without the macro: pc_o=0x203 and misalign_o=0.
